// File: rtl/sram_rq_ctrl.sv
// -----------------------------------------------------------------------------
// sram_rq_ctrl
//
// Sequencer that turns single-beat read/write requests into SRAM array
// control: bitline precharge, wordline drive, write-driver enable and
// sense-amp enable, followed by a one-clock read-data-valid response.
//
// Ports
//   clk         - single clock, all state changes on the rising edge
//   nrst        - asynchronous active-low reset
//   mac_en_i    - an external MAC owns the array; no new requests accepted
//   rq_valid_i  - request valid (level handshake with rq_ready_o)
//   rq_wr_i     - 1 = write, 0 = read
//   addr_i      - row address
//   wr_data_i   - write data
//   rq_ready_o  - request is taken on a rising edge where valid && ready
//   rd_valid_o  - one-clock pulse when rd_data_o carries fresh read data
//   rd_data_o   - last captured read data, held until the next read
//   WL          - one-hot wordline
//   PCH         - bitline precharge, active high
//   WRITE       - write-driver enable
//   WR_DATA     - write-driver data
//   CSEL        - column select
//   SAEN        - sense-amp enable
//   SA_OUT      - sense-amp outputs from the array
// -----------------------------------------------------------------------------
module sram_rq_ctrl #(
  parameter int numRows     = 128,
  parameter int numCols     = 32,
  parameter int pchCycles   = 1,
  parameter int senseCycles = 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       mac_en_i,
  input  logic                       rq_valid_i,
  input  logic                       rq_wr_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic                       WRITE,
  output logic [numCols-1:0]         WR_DATA,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);

  localparam int AddrW  = $clog2(numRows);
  // One shared down-counter serves both the precharge and the sense phase.
  localparam int CntMax = (pchCycles > senseCycles) ? pchCycles : senseCycles;
  localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PCH   = 3'd1,
    S_WR    = 3'd2,
    S_RWL   = 3'd3,
    S_SENSE = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [CntW-1:0]     cnt_r;
  logic [CntW-1:0]     next_cnt_s;
  logic [AddrW-1:0]    addr_r;
  logic [numCols-1:0]  wdata_r;
  logic                wr_r;
  logic                ready_s;
  logic                accept_s;
  logic                capture_s;

  logic [numRows-1:0]  wl_s;
  logic                pch_s;
  logic                write_s;
  logic [numCols-1:0]  wr_data_s;
  logic [numCols-1:0]  csel_s;
  logic                saen_s;
  logic                rd_valid_s;

  logic [numRows-1:0]  wl_r;
  logic                pch_r;
  logic                write_r;
  logic [numCols-1:0]  wr_data_r;
  logic [numCols-1:0]  csel_r;
  logic                saen_r;
  logic                rd_valid_r;
  logic [numCols-1:0]  rd_data_r;

  // Ready is a pure decode of the registered state; the MAC only gates new work.
  assign ready_s    = (state_r == S_IDLE) && !mac_en_i;
  assign accept_s   = ready_s && rq_valid_i;
  assign rq_ready_o = ready_s;

  assign WL         = wl_r;
  assign PCH        = pch_r;
  assign WRITE      = write_r;
  assign WR_DATA    = wr_data_r;
  assign CSEL       = csel_r;
  assign SAEN       = saen_r;
  assign rd_valid_o = rd_valid_r;
  assign rd_data_o  = rd_data_r;

  // Next-state and phase-counter logic.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    capture_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          next_state_s = S_PCH;
          next_cnt_s   = CntW'(pchCycles - 1);
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_PCH: begin
        if (cnt_r == {CntW{1'b0}}) begin
          if (wr_r) begin
            next_state_s = S_WR;
          end else begin
            next_state_s = S_RWL;
          end
        end else begin
          next_cnt_s = cnt_r - CntW'(1);
        end
      end
      S_WR: begin
        next_state_s = S_IDLE;
      end
      S_RWL: begin
        next_state_s = S_SENSE;
        next_cnt_s   = CntW'(senseCycles - 1);
      end
      S_SENSE: begin
        if (cnt_r == {CntW{1'b0}}) begin
          next_state_s = S_RESP;
          capture_s    = 1'b1;
        end else begin
          next_cnt_s = cnt_r - CntW'(1);
        end
      end
      S_RESP: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
        next_cnt_s   = {CntW{1'b0}};
      end
    endcase
  end

  // Array-side controls are decoded from the NEXT state and registered, so the
  // pins change cleanly on the edge that enters each phase.
  always_comb begin
    wl_s       = {numRows{1'b0}};
    pch_s      = 1'b0;
    write_s    = 1'b0;
    wr_data_s  = {numCols{1'b0}};
    csel_s     = {numCols{1'b0}};
    saen_s     = 1'b0;
    rd_valid_s = 1'b0;
    case (next_state_s)
      S_IDLE: begin
        rd_valid_s = 1'b0;
      end
      S_PCH: begin
        pch_s = 1'b1;
      end
      S_WR: begin
        wl_s[addr_r] = 1'b1;
        write_s      = 1'b1;
        wr_data_s    = wdata_r;
        csel_s       = {numCols{1'b1}};
      end
      S_RWL: begin
        wl_s[addr_r] = 1'b1;
      end
      S_SENSE: begin
        wl_s[addr_r] = 1'b1;
        saen_s       = 1'b1;
      end
      S_RESP: begin
        rd_valid_s = 1'b1;
      end
      default: begin
        rd_valid_s = 1'b0;
      end
    endcase
  end

  // State register, phase counter and request latch.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CntW{1'b0}};
      addr_r  <= {AddrW{1'b0}};
      wdata_r <= {numCols{1'b0}};
      wr_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      if (accept_s) begin
        addr_r  <= addr_i;
        wdata_r <= wr_data_i;
        wr_r    <= rq_wr_i;
      end
    end
  end

  // Registered array controls and read-valid pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wl_r       <= {numRows{1'b0}};
      pch_r      <= 1'b0;
      write_r    <= 1'b0;
      wr_data_r  <= {numCols{1'b0}};
      csel_r     <= {numCols{1'b0}};
      saen_r     <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      wl_r       <= wl_s;
      pch_r      <= pch_s;
      write_r    <= write_s;
      wr_data_r  <= wr_data_s;
      csel_r     <= csel_s;
      saen_r     <= saen_s;
      rd_valid_r <= rd_valid_s;
    end
  end

  // Read data is sampled from the sense amps on the last sense edge and then
  // held; writes never touch it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data_r <= {numCols{1'b0}};
    end else if (capture_s) begin
      rd_data_r <= SA_OUT;
    end
  end

endmodule

// File: tb/tb_sram_rq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_rq_ctrl
//
// Directed bring-up steps followed by a randomized read/write mix. A simple
// behavioural SRAM array answers the controller's pins; an independent
// reference memory (updated per accepted write) supplies the expected read
// data, and the per-cycle pin expectations come from the phase sequence
// PCH -> WR, or PCH -> RWL -> SENSE -> RESP.
// -----------------------------------------------------------------------------
module tb_sram_rq_ctrl;

  localparam int NR = 128;
  localparam int NC = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          nrst;
  logic          mac_en;
  logic          rq_valid;
  logic          rq_wr;
  logic [AW-1:0] addr;
  logic [NC-1:0] wr_data;
  logic          rq_ready;
  logic          rd_valid;
  logic [NC-1:0] rd_data;
  logic [NR-1:0] WL;
  logic          PCH;
  logic          WRITE;
  logic [NC-1:0] WR_DATA;
  logic [NC-1:0] CSEL;
  logic          SAEN;
  logic [NC-1:0] sa_out;

  int checks   = 0;
  int failures = 0;

  logic [NC-1:0] sram    [NR];
  logic [NC-1:0] ref_mem [NR];
  bit            written [NR];
  int            written_q[$];
  logic [NC-1:0] last_rd;

  always #5 clk = ~clk;

  sram_rq_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .mac_en_i   (mac_en),
    .rq_valid_i (rq_valid),
    .rq_wr_i    (rq_wr),
    .addr_i     (addr),
    .wr_data_i  (wr_data),
    .rq_ready_o (rq_ready),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .WL         (WL),
    .PCH        (PCH),
    .WRITE      (WRITE),
    .WR_DATA    (WR_DATA),
    .CSEL       (CSEL),
    .SAEN       (SAEN),
    .SA_OUT     (sa_out)
  );

  // Behavioural array: stores on WRITE, drives the selected row on SAEN.
  always @(posedge clk) begin
    if (WRITE) begin
      for (int i = 0; i < NR; i++) begin
        if (WL[i]) sram[i] <= WR_DATA;
      end
    end
  end

  always_comb begin
    sa_out = 32'hDEAD_BEEF;
    if (SAEN) begin
      for (int i = 0; i < NR; i++) begin
        if (WL[i]) sa_out = sram[i];
      end
    end
  end

  task automatic check(input string tag, input logic [NR-1:0] obs, input logic [NR-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int a);
    logic [NR-1:0] one;
    one = {{(NR-1){1'b0}}, 1'b1};
    return one << a;
  endfunction

  // Continuous invariants: single wordline, exclusive array phases.
  always @(negedge clk) begin
    if (nrst) begin
      check("wl_onehot0", NR'($onehot0(WL)), NR'(1));
      check("phase_excl", NR'($onehot0({PCH, WRITE, SAEN})), NR'(1));
    end
  end

  task automatic scramble();
    rq_wr   = 1'($urandom);
    addr    = AW'($urandom);
    wr_data = $urandom;
  endtask

  task automatic note_write(input int a, input logic [NC-1:0] d);
    ref_mem[a] = d;
    if (!written[a]) begin
      written[a] = 1'b1;
      written_q.push_back(a);
    end
  endtask

  task automatic do_write(input int a, input logic [NC-1:0] d);
    @(negedge clk);
    rq_valid = 1'b1; rq_wr = 1'b1; addr = AW'(a); wr_data = d;
    check("wr_ready", NR'(rq_ready), NR'(1));
    @(negedge clk);
    rq_valid = 1'b0; scramble();
    check("wr_c1_pch", NR'(PCH), NR'(1));
    check("wr_c1_wl", WL, '0);
    check("wr_c1_write", NR'(WRITE), NR'(0));
    @(negedge clk);
    check("wr_c2_wl", WL, onehot(a));
    check("wr_c2_write", NR'(WRITE), NR'(1));
    check("wr_c2_data", NR'(WR_DATA), NR'(d));
    check("wr_c2_csel", NR'(CSEL), NR'({NC{1'b1}}));
    check("wr_c2_pch", NR'(PCH), NR'(0));
    check("wr_c2_ready", NR'(rq_ready), NR'(0));
    note_write(a, d);
    @(negedge clk);
    check("wr_c3_ready", NR'(rq_ready), NR'(!mac_en));
    check("wr_c3_wl", WL, '0);
    check("wr_c3_write", NR'(WRITE), NR'(0));
    check("wr_c3_wrdata", NR'(WR_DATA), NR'(0));
    check("wr_c3_csel", NR'(CSEL), NR'(0));
    check("wr_keeps_rd", NR'(rd_data), NR'(last_rd));
  endtask

  task automatic do_read(input int a, input bit mac_at_sense);
    @(negedge clk);
    rq_valid = 1'b1; rq_wr = 1'b0; addr = AW'(a); wr_data = $urandom;
    check("rd_ready", NR'(rq_ready), NR'(1));
    @(negedge clk);
    rq_valid = 1'b0; scramble();
    check("rd_c1_pch", NR'(PCH), NR'(1));
    check("rd_c1_wl", WL, '0);
    check("rd_c1_saen", NR'(SAEN), NR'(0));
    @(negedge clk);
    check("rd_c2_wl", WL, onehot(a));
    check("rd_c2_pch", NR'(PCH), NR'(0));
    check("rd_c2_saen", NR'(SAEN), NR'(0));
    check("rd_c2_csel", NR'(CSEL), NR'(0));
    @(negedge clk);
    check("rd_c3_wl", WL, onehot(a));
    check("rd_c3_saen", NR'(SAEN), NR'(1));
    check("rd_c3_valid", NR'(rd_valid), NR'(0));
    if (mac_at_sense) mac_en = 1'b1;
    @(negedge clk);
    check("rd_c4_valid", NR'(rd_valid), NR'(1));
    check("rd_c4_data", NR'(rd_data), NR'(ref_mem[a]));
    check("rd_c4_wl", WL, '0);
    check("rd_c4_saen", NR'(SAEN), NR'(0));
    last_rd = ref_mem[a];
    @(negedge clk);
    check("rd_c5_valid", NR'(rd_valid), NR'(0));
    check("rd_c5_hold", NR'(rd_data), NR'(last_rd));
    check("rd_c5_ready", NR'(rq_ready), NR'(!mac_en));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] d1, d2;
    nrst = 1'b1; mac_en = 1'b0; rq_valid = 1'b0; rq_wr = 1'b0;
    addr = '0; wr_data = '0; last_rd = '0;
    #2 nrst = 1'b0;

    // Reset: outputs all zero while held.
    repeat (2) begin
      @(negedge clk);
      check("rst_wl", WL, '0);
      check("rst_pch", NR'(PCH), NR'(0));
      check("rst_write", NR'(WRITE), NR'(0));
      check("rst_wrdata", NR'(WR_DATA), NR'(0));
      check("rst_csel", NR'(CSEL), NR'(0));
      check("rst_saen", NR'(SAEN), NR'(0));
      check("rst_rdvalid", NR'(rd_valid), NR'(0));
      check("rst_rddata", NR'(rd_data), NR'(0));
    end
    nrst = 1'b1;
    #1 check("rst_rel_ready", NR'(rq_ready), NR'(1));

    // Basic write then read-back of row 5.
    do_write(5, 32'hA5A5A5A5);
    do_read(5, 1'b0);
    do_write(127, 32'h1234_5678);
    do_write(0, 32'h0F0F_0001);
    do_write(7, 32'hCAFE_F00D);

    // MAC ownership while idle blocks acceptance and array activity.
    @(negedge clk);
    mac_en = 1'b1; rq_valid = 1'b1; rq_wr = 1'b1; addr = 7'd9; wr_data = 32'hFFFF_0000;
    #1 check("mac_idle_ready", NR'(rq_ready), NR'(0));
    repeat (3) begin
      @(negedge clk);
      check("mac_idle_ready_hold", NR'(rq_ready), NR'(0));
      check("mac_idle_pch", NR'(PCH), NR'(0));
      check("mac_idle_wl", WL, '0);
      check("mac_idle_write", NR'(WRITE), NR'(0));
    end
    rq_valid = 1'b0; mac_en = 1'b0;

    // MAC rises during SENSE of a read to row 127: read still completes.
    do_read(127, 1'b1);
    @(negedge clk);
    rq_valid = 1'b1; rq_wr = 1'b0; addr = 7'd3;
    @(negedge clk);
    check("mac_after_ready", NR'(rq_ready), NR'(0));
    check("mac_after_pch", NR'(PCH), NR'(0));
    rq_valid = 1'b0; mac_en = 1'b0;

    // Reset during SENSE discards the read.
    @(negedge clk);
    rq_valid = 1'b1; rq_wr = 1'b0; addr = 7'd7;
    @(negedge clk);
    rq_valid = 1'b0;
    check("rstmid_c1_pch", NR'(PCH), NR'(1));
    @(negedge clk);
    @(negedge clk);
    check("rstmid_sense", NR'(SAEN), NR'(1));
    nrst = 1'b0;
    #1;
    check("rstmid_saen_drop", NR'(SAEN), NR'(0));
    check("rstmid_wl_drop", WL, '0);
    check("rstmid_rdvalid", NR'(rd_valid), NR'(0));
    @(negedge clk);
    check("rstmid_rdvalid_hold", NR'(rd_valid), NR'(0));
    nrst = 1'b1;
    last_rd = '0;
    repeat (2) begin
      @(negedge clk);
      check("rstmid_no_pulse", NR'(rd_valid), NR'(0));
      check("rstmid_ready", NR'(rq_ready), NR'(1));
    end
    do_read(0, 1'b0);

    // Back-to-back writes with rq_valid held high.
    d1 = 32'h1111_AAAA; d2 = 32'h2222_BBBB;
    @(negedge clk);
    rq_valid = 1'b1; rq_wr = 1'b1; addr = 7'd1; wr_data = d1;
    check("b2b_ready0", NR'(rq_ready), NR'(1));
    @(negedge clk);
    addr = 7'd2; wr_data = d2;
    check("b2b_c1_pch", NR'(PCH), NR'(1));
    @(negedge clk);
    check("b2b_c2_wl", WL, onehot(1));
    check("b2b_c2_data", NR'(WR_DATA), NR'(d1));
    check("b2b_c2_ready", NR'(rq_ready), NR'(0));
    @(negedge clk);
    check("b2b_c3_ready", NR'(rq_ready), NR'(1));
    @(negedge clk);
    rq_valid = 1'b0;
    check("b2b_c4_pch", NR'(PCH), NR'(1));
    check("b2b_c4_wl", WL, '0);
    @(negedge clk);
    check("b2b_c5_wl", WL, onehot(2));
    check("b2b_c5_data", NR'(WR_DATA), NR'(d2));
    @(negedge clk);
    check("b2b_c6_ready", NR'(rq_ready), NR'(1));
    check("b2b_c6_wl", WL, '0);
    note_write(1, d1);
    note_write(2, d2);
    do_read(1, 1'b0);
    do_read(2, 1'b0);

    // Randomized mix against the reference memory.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write(int'($urandom_range(0, NR - 1)), $urandom);
      end else begin
        do_read(written_q[$urandom_range(0, written_q.size() - 1)], 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
